// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative HI/LO multiply/divide unit with MTHI/MTLO.
// Config: define HILO_DIV_EN to build the DIV/DIVU restoring divider.
// Ports: clk, reset_n (sync, active-low), start/op/operand_a/operand_b
// request; busy, done, div_by_zero, illegal_op status; hi_out/lo_out.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_by_zero,
    output logic             illegal_op
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
`ifdef HILO_DIV_EN
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
`endif
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] mcand;
    logic             neg_p;

    logic             sgn;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] fix_prod;

    // op[0] clear selects the signed flavour of MULT/DIV
    always_comb begin
        sgn = ~op[0];
        a_mag = (sgn && operand_a[WIDTH-1]) ? -operand_a : operand_a;
        b_mag = (sgn && operand_b[WIDTH-1]) ? -operand_b : operand_b;
    end

    // Shift-add step: acc_lo holds the multiplier, shifted out LSB first,
    // while product bits shift in from the top.
    always_comb begin
        sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        mul_hi = sum[WIDTH:1];
        mul_lo = {sum[0], acc_lo[WIDTH-1:1]};
        prod = {acc_hi, acc_lo};
        fix_prod = neg_p ? -prod : prod;
    end

`ifdef HILO_DIV_EN
    logic             neg_r;
    logic             is_div;
    logic [WIDTH:0]   shl;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;
    logic [WIDTH-1:0] fix_q;
    logic [WIDTH-1:0] fix_r;

    // Restoring step: acc_hi is the partial remainder, acc_lo the
    // dividend shifting out MSB first with quotient bits shifting in.
    always_comb begin
        shl = {acc_hi, acc_lo[WIDTH-1]};
        diff = shl - {1'b0, mcand};
        div_hi = diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
        div_lo = {acc_lo[WIDTH-2:0], ~diff[WIDTH]};
        fix_q = neg_p ? -acc_lo : acc_lo;
        fix_r = neg_r ? -acc_hi : acc_hi;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
            hi_out      <= '0;
            lo_out      <= '0;
            cnt         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            mcand       <= '0;
            neg_p       <= 1'b0;
`ifdef HILO_DIV_EN
            neg_r       <= 1'b0;
            is_div      <= 1'b0;
`endif
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        unique case (op)
                            OP_MULT, OP_MULTU: begin
                                state  <= MUL;
                                busy   <= 1'b1;
                                cnt    <= CW'(WIDTH - 1);
                                acc_hi <= '0;
                                acc_lo <= b_mag;
                                mcand  <= a_mag;
                                neg_p  <= sgn & (operand_a[WIDTH-1]
                                               ^ operand_b[WIDTH-1]);
`ifdef HILO_DIV_EN
                                is_div <= 1'b0;
`endif
                            end
`ifdef HILO_DIV_EN
                            OP_DIV, OP_DIVU: begin
                                if (operand_b == '0) begin
                                    done        <= 1'b1;
                                    div_by_zero <= 1'b1;
                                end else begin
                                    state  <= DIV;
                                    busy   <= 1'b1;
                                    cnt    <= CW'(WIDTH - 1);
                                    acc_hi <= '0;
                                    acc_lo <= a_mag;
                                    mcand  <= b_mag;
                                    neg_p  <= sgn & (operand_a[WIDTH-1]
                                                   ^ operand_b[WIDTH-1]);
                                    neg_r  <= sgn & operand_a[WIDTH-1];
                                    is_div <= 1'b1;
                                end
                            end
`endif
                            OP_MTHI: begin
                                hi_out <= operand_a;
                                done   <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo_out <= operand_a;
                                done   <= 1'b1;
                            end
                            default: begin
                                done       <= 1'b1;
                                illegal_op <= 1'b1;
                            end
                        endcase
                    end
                end
                MUL: begin
                    acc_hi <= mul_hi;
                    acc_lo <= mul_lo;
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
`ifdef HILO_DIV_EN
                DIV: begin
                    acc_hi <= div_hi;
                    acc_lo <= div_lo;
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
`endif
                FIX: begin
`ifdef HILO_DIV_EN
                    if (is_div) begin
                        hi_out <= fix_r;
                        lo_out <= fix_q;
                    end else begin
                        {hi_out, lo_out} <= fix_prod;
                    end
`else
                    {hi_out, lo_out} <= fix_prod;
`endif
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed-vector bench for hilo_muldiv_unit.
// Divider vectors follow HILO_DIV_EN; without it DIV/DIVU must be illegal.
module tb_hilo_muldiv_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_by_zero;
    logic        illegal_op;

    int n_chk = 0;
    int n_err = 0;

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .op(op),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .busy(busy),
        .done(done),
        .hi_out(hi_out),
        .lo_out(lo_out),
        .div_by_zero(div_by_zero),
        .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // elat: edges after the accept edge until done is visible
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int elat, input int ebusy,
                          input logic edbz, input logic eill);
        logic [31:0] h0;
        logic [31:0] l0;
        int lat;
        int nb;
        logic moved;
        @(negedge clk);
        h0 = hi_out;
        l0 = lo_out;
        op = o;
        operand_a = a;
        operand_b = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        nb = 0;
        moved = 1'b0;
        while (!done && lat < 200) begin
            if (busy) nb++;
            if (hi_out !== h0 || lo_out !== l0) moved = 1'b1;
            operand_a = ~operand_a;
            operand_b = operand_b + 32'd1;
            op = 3'b100;
            @(negedge clk);
            lat++;
        end
        check({tag, "/lat"}, 64'(lat), 64'(elat));
        check({tag, "/busy_cycles"}, 64'(nb), 64'(ebusy));
        check({tag, "/busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "/hi"}, 64'(hi_out), 64'(ehi));
        check({tag, "/lo"}, 64'(lo_out), 64'(elo));
        check({tag, "/dbz"}, 64'(div_by_zero), 64'(edbz));
        check({tag, "/ill"}, 64'(illegal_op), 64'(eill));
        check({tag, "/hilo_stable"}, 64'(moved), 64'd0);
        @(negedge clk);
        check({tag, "/done_single"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [31:0] h0;
        int ndone;
        reset_n = 1'b0;
        start = 1'b0;
        op = 3'b000;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(negedge clk);
        check("rst/busy", 64'(busy), 64'd0);
        check("rst/done", 64'(done), 64'd0);
        check("rst/hi", 64'(hi_out), 64'd0);
        check("rst/lo", 64'(lo_out), 64'd0);
        check("rst/dbz", 64'(div_by_zero), 64'd0);
        check("rst/ill", 64'(illegal_op), 64'd0);
        reset_n = 1'b1;

        run_op("mult_m1x2", 3'b000, 32'hFFFF_FFFF, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 33, 0, 0);
        run_op("multu_m1x2", 3'b001, 32'hFFFF_FFFF, 32'd2,
               32'h0000_0001, 32'hFFFF_FFFE, 33, 33, 0, 0);
        run_op("mult_minxmin", 3'b000, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 32'h0000_0000, 33, 33, 0, 0);
        run_op("mult_7xm3", 3'b000, 32'd7, 32'hFFFF_FFFD,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 33, 0, 0);
        run_op("mthi", 3'b100, 32'h1234_5678, 32'd9,
               32'h1234_5678, 32'hFFFF_FFEB, 0, 0, 0, 0);
        run_op("mtlo", 3'b101, 32'hCAFE_F00D, 32'd9,
               32'h1234_5678, 32'hCAFE_F00D, 0, 0, 0, 0);
        run_op("ill_110", 3'b110, 32'd1, 32'd2,
               32'h1234_5678, 32'hCAFE_F00D, 0, 0, 0, 1);
        run_op("ill_111", 3'b111, 32'd1, 32'd2,
               32'h1234_5678, 32'hCAFE_F00D, 0, 0, 0, 1);

`ifdef HILO_DIV_EN
        run_op("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 33, 0, 0);
        run_op("div_min_m1", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000, 33, 33, 0, 0);
        run_op("div_7_m2", 3'b010, 32'd7, 32'hFFFF_FFFE,
               32'h0000_0001, 32'hFFFF_FFFD, 33, 33, 0, 0);
        run_op("divu_100_7", 3'b011, 32'd100, 32'd7,
               32'h0000_0002, 32'h0000_000E, 33, 33, 0, 0);
        run_op("divu_max_1", 3'b011, 32'hFFFF_FFFF, 32'd1,
               32'h0000_0000, 32'hFFFF_FFFF, 33, 33, 0, 0);
        run_op("divu_10_0", 3'b011, 32'd10, 32'd0,
               32'h0000_0000, 32'hFFFF_FFFF, 0, 0, 1, 0);
`else
        run_op("divu_10_3_ill", 3'b011, 32'd10, 32'd3,
               32'h1234_5678, 32'hCAFE_F00D, 0, 0, 0, 1);
        run_op("div_m7_2_ill", 3'b010, 32'hFFFF_FFF9, 32'd2,
               32'h1234_5678, 32'hCAFE_F00D, 0, 0, 0, 1);
`endif

        // MULT aborted by reset; MTHI issued while busy must be dropped
        @(negedge clk);
        h0 = hi_out;
        op = 3'b000;
        operand_a = 32'd3;
        operand_b = 32'd5;
        start = 1'b1;
        ndone = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done) ndone++;
            start = 1'b0;
            if (c == 5) begin
                op = 3'b100;
                operand_a = 32'hDEAD_BEEF;
                start = 1'b1;
            end
            if (c == 9) begin
                check("abort/busy_pre", 64'(busy), 64'd1);
                check("abort/hi_pre", 64'(hi_out), 64'(h0));
                reset_n = 1'b0;
            end
        end
        check("abort/no_done", 64'(ndone), 64'd0);
        check("abort/busy", 64'(busy), 64'd0);
        check("abort/hi", 64'(hi_out), 64'd0);
        check("abort/lo", 64'(lo_out), 64'd0);
        reset_n = 1'b1;
        run_op("post_rst_mtlo", 3'b101, 32'h0000_00A5, 32'd0,
               32'h0000_0000, 32'h0000_00A5, 0, 0, 0, 0);

        // start together with reset must be ignored
        @(negedge clk);
        reset_n = 1'b0;
        op = 3'b100;
        operand_a = 32'h0000_0055;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset_n = 1'b1;
        check("rst_start/hi", 64'(hi_out), 64'd0);
        check("rst_start/done", 64'(done), 64'd0);
        check("rst_start/busy", 64'(busy), 64'd0);
        run_op("multu_2p16sq", 3'b001, 32'h0001_0000, 32'h0001_0000,
               32'h0000_0001, 32'h0000_0000, 33, 33, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and HI/LO register width (legal range 8..64, even).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1, operation request, sampled at the rising edge of clk.
REQ-005 SHALL have port op, input, 3, operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 illegal.
REQ-006 SHALL have ports operand_a and operand_b, input, WIDTH; rs/rt values, sampled with start.
REQ-007 SHALL have port busy, output, 1, iteration in progress; new start ignored.
REQ-008 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-009 SHALL have ports hi_out and lo_out, output, WIDTH, registered HI and LO contents.
REQ-010 SHALL have ports div_by_zero and illegal_op, output, 1, status pulses coincident with done.

Function
REQ-011 States: IDLE, MUL, DIV, FIX; start is accepted only in IDLE, and start while busy=1 is ignored with no side effects.
REQ-012 MULT/MULTU: IDLE->MUL at accept edge E0; WIDTH shift-add iterations on operand magnitudes; MUL->FIX; FIX applies sign correction (signed ops only), writes {hi_out,lo_out} = 2*WIDTH-bit product at edge E0+WIDTH+1, returns to IDLE.
REQ-013 DIV/DIVU with operand_b!=0: same timing as REQ-012 via the DIV state (restoring, one quotient bit per cycle); lo_out=quotient, hi_out=remainder.
REQ-014 Signed division SHALL truncate toward zero, with the remainder taking the dividend's sign; MIN/-1 yields lo_out=MIN, hi_out=0 (wrap, no flag).
REQ-015 busy SHALL be 1 from the cycle after E0 through the cycle ending at E0+WIDTH+1, inclusive; done SHALL be 1 for exactly the cycle after the HI/LO write edge, and busy SHALL be 0 in that cycle.
REQ-016 MTHI/MTLO: hi_out (or lo_out) <= operand_a at E0; the other register is unchanged; done is pulsed in the following cycle; busy is never asserted.
REQ-017 DIV/DIVU with operand_b==0: no iteration; HI/LO are unchanged; done and div_by_zero pulse in the cycle after E0; busy stays 0.
REQ-018 Illegal op: HI/LO are unchanged; done and illegal_op pulse in the cycle after E0.
REQ-019 hi_out/lo_out SHALL hold their value between writes; intermediate iteration values SHALL never appear on them.
REQ-020 Operands SHALL be captured at E0; operand changes during busy SHALL NOT affect the result.

Reset
REQ-021 When reset_n=0 at a clock edge: state->IDLE, busy=0, done=0, div_by_zero=0, illegal_op=0, hi_out=0, lo_out=0.
REQ-022 Reset mid-operation SHALL abort the operation with no done pulse; the first start after reset_n returns to 1 is accepted normally.
REQ-023 start coincident with reset_n=0 SHALL be ignored.

Configuration
REQ-024 Macro HILO_DIV_EN: when defined, DIV/DIVU behave per REQ-013/014/017.
REQ-025 Without HILO_DIV_EN: op 010/011 are treated as illegal per REQ-018, and no divider datapath is synthesised.

Verification (WIDTH=32, HILO_DIV_EN defined unless noted)
REQ-026 MULT a=32'hFFFF_FFFF (-1), b=32'h0000_0002 -> after 33 cycles HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFE, single done pulse.
REQ-027 MULTU same operands -> HI=32'h0000_0001, LO=32'hFFFF_FFFE.
REQ-028 DIV a=-7, b=2 -> LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1); DIV a=32'h8000_0000, b=-1 -> LO=32'h8000_0000, HI=0.
REQ-029 DIVU a=10, b=0 -> done+div_by_zero pulse one cycle after start, HI/LO unchanged, busy=0 throughout.
REQ-030 MULT started, second start (MTHI) issued at cycle 5, reset_n=0 at cycle 10 -> second start ignored, no done, HI=LO=0, busy=0 after reset.
REQ-031 HILO_DIV_EN undefined, DIVU 10/3 -> illegal_op+done one cycle after start, HI/LO unchanged.
